// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared types and default constants for the counter
// sequencer.
//   counter_ctrl_state_t : sequencer FSM state encoding
//   CTRL_WIDTH           : default counter value width
//   CTRL_REP_W           : default repeat-field width
//   CTRL_TIMEOUT         : default RUN-cycle budget per run (watchdog builds)
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESULT = 2'd3
  } counter_ctrl_state_t;

  localparam int CTRL_WIDTH   = 4;
  localparam int CTRL_REP_W   = 4;
  localparam int CTRL_TIMEOUT = 64;

endpackage

// File: rtl/counter_ctrl_wdog.sv
// counter_ctrl_wdog: RUN-cycle watchdog for the counter sequencer.
// Counts tick cycles since the last clr; expired pulses combinationally in the
// tick cycle that is the TIMEOUT-th one since clr.
// Ports:
//   clk_i    : clock
//   reset_i  : asynchronous reset, active-high
//   clr      : restart the count (held during LOAD)
//   tick     : one RUN cycle elapsed
//   expired  : TIMEOUT-th tick seen in this cycle
module counter_ctrl_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  assign expired = tick && (count_q == LAST);

  // Saturates at LAST: the sequencer leaves RUN on expiry anyway.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (tick && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencer in front of a configurable counter. Accepts a job
// (init/inc/target/reps), loads the counter through its synchronous reset,
// enables it until done, repeats reps+1 times, then offers the last count.
// Optional feature macro: COUNTER_CTRL_TIMEOUT_EN adds a per-run watchdog
// (TIMEOUT RUN cycles) that aborts the job and flags res_err_o.
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready
// are both high; the offering side holds its payload stable until then.
// Ports:
//   clk_i, reset_i                          : clock, async active-high reset
//   cfg_valid_i/cfg_ready_o                 : job handshake
//   cfg_init_i/cfg_inc_i/cfg_target_i       : counter settings for the job
//   cfg_reps_i                              : extra runs (job runs reps+1 times)
//   cnt_reset_o/cnt_enable_o                : counter sync reset / enable
//   cnt_init_o/cnt_inc_o/cnt_target_o       : registered counter settings
//   cnt_value_i/cnt_done_i                  : counter value / done (enable-qualified)
//   res_valid_o/res_ready_i                 : result handshake
//   res_value_o/res_runs_o/res_err_o        : captured value, runs done, timeout
//   busy_o                                  : not idle
//   state_o                                 : current FSM state (debug)
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH   = CTRL_WIDTH,
  parameter int REP_W   = CTRL_REP_W,
  parameter int TIMEOUT = CTRL_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [WIDTH-1:0]    cfg_init_i,
  input  logic [WIDTH-1:0]    cfg_inc_i,
  input  logic [WIDTH-1:0]    cfg_target_i,
  input  logic [REP_W-1:0]    cfg_reps_i,
  output logic                cnt_reset_o,
  output logic                cnt_enable_o,
  output logic [WIDTH-1:0]    cnt_init_o,
  output logic [WIDTH-1:0]    cnt_inc_o,
  output logic [WIDTH-1:0]    cnt_target_o,
  input  logic [WIDTH-1:0]    cnt_value_i,
  input  logic                cnt_done_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [WIDTH-1:0]    res_value_o,
  output logic [REP_W:0]      res_runs_o,
  output logic                res_err_o,
  output logic                busy_o,
  output counter_ctrl_state_t state_o
);

  counter_ctrl_state_t state_q, state_d;

  logic [REP_W-1:0] remaining_q;
  logic [WIDTH-1:0] res_value_q;
  logic [REP_W:0]   res_runs_q;
  logic             accept;
  logic             timeout_hit;

  assign accept = (state_q == ST_IDLE) && cfg_valid_i;

`ifdef COUNTER_CTRL_TIMEOUT_EN
  logic wdog_expired;
  logic res_err_q;

  counter_ctrl_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (state_q == ST_LOAD),
    .tick    (state_q == ST_RUN),
    .expired (wdog_expired)
  );

  // Done wins over a coincident expiry.
  assign timeout_hit = wdog_expired && !cnt_done_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      res_err_q <= 1'b0;
    end else if (accept) begin
      res_err_q <= 1'b0;
    end else if (timeout_hit) begin
      res_err_q <= 1'b1;
    end
  end

  assign res_err_o = res_err_q;
`else
  assign timeout_hit = 1'b0;
  assign res_err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cfg_valid_i) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_RUN;
      ST_RUN: begin
        if (cnt_done_i) begin
          state_d = (remaining_q == '0) ? ST_RESULT : ST_LOAD;
        end else if (timeout_hit) begin
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: if (res_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_init_o   <= '0;
      cnt_inc_o    <= '0;
      cnt_target_o <= '0;
      remaining_q  <= '0;
      res_value_q  <= '0;
      res_runs_q   <= '0;
    end else if (accept) begin
      cnt_init_o   <= cfg_init_i;
      cnt_inc_o    <= cfg_inc_i;
      cnt_target_o <= cfg_target_i;
      remaining_q  <= cfg_reps_i;
      res_value_q  <= '0;
      res_runs_q   <= '0;
    end else if (state_q == ST_RUN) begin
      if (cnt_done_i) begin
        res_value_q <= cnt_value_i;
        res_runs_q  <= res_runs_q + 1'b1;
        if (remaining_q != '0) remaining_q <= remaining_q - 1'b1;
      end else if (timeout_hit) begin
        res_value_q <= cnt_value_i;
        remaining_q <= '0;
      end
    end
  end

  assign cfg_ready_o  = (state_q == ST_IDLE);
  // Counter is held in reset whenever it is not running, so it never
  // wanders between jobs.
  assign cnt_reset_o  = (state_q != ST_RUN);
  assign cnt_enable_o = (state_q == ST_RUN);
  assign res_valid_o  = (state_q == ST_RESULT);
  assign res_value_o  = res_value_q;
  assign res_runs_o   = res_runs_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed bench for counter_ctrl with a behavioural model of
// the downstream counter (sync reset loads init, enable adds inc, done when
// enabled and value >= target).
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int RW = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [W-1:0]  cfg_init_i = '0, cfg_inc_i = '0, cfg_target_i = '0;
  logic [RW-1:0] cfg_reps_i = '0;
  logic          cnt_reset_o, cnt_enable_o;
  logic [W-1:0]  cnt_init_o, cnt_inc_o, cnt_target_o;
  logic [W-1:0]  cnt_value_i;
  logic          cnt_done_i;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [W-1:0]  res_value_o;
  logic [RW:0]   res_runs_o;
  logic          res_err_o;
  logic          busy_o;
  counter_ctrl_state_t state_o;

  int checks = 0;
  int errors = 0;

  counter_ctrl #(
    .WIDTH   (W),
    .REP_W   (RW),
    .TIMEOUT (8)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_init_i   (cfg_init_i),
    .cfg_inc_i    (cfg_inc_i),
    .cfg_target_i (cfg_target_i),
    .cfg_reps_i   (cfg_reps_i),
    .cnt_reset_o  (cnt_reset_o),
    .cnt_enable_o (cnt_enable_o),
    .cnt_init_o   (cnt_init_o),
    .cnt_inc_o    (cnt_inc_o),
    .cnt_target_o (cnt_target_o),
    .cnt_value_i  (cnt_value_i),
    .cnt_done_i   (cnt_done_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_value_o  (res_value_o),
    .res_runs_o   (res_runs_o),
    .res_err_o    (res_err_o),
    .busy_o       (busy_o),
    .state_o      (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- downstream counter model ----------------
  logic [W-1:0] model_value = '0;
  always_ff @(posedge clk_i) begin
    if (cnt_reset_o)       model_value <= cnt_init_o;
    else if (cnt_enable_o) model_value <= model_value + cnt_inc_o;
  end
  assign cnt_value_i = model_value;
  assign cnt_done_i  = cnt_enable_o && (model_value >= cnt_target_o);

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: offers a job for the next rising edge (cycle 0),
  // returns at the negedge of cycle 1 with cfg_valid_i dropped.
  task automatic offer_job(input logic [W-1:0] init, input logic [W-1:0] inc,
                           input logic [W-1:0] tgt, input logic [RW-1:0] reps);
    cfg_init_i   = init;
    cfg_inc_i    = inc;
    cfg_target_i = tgt;
    cfg_reps_i   = reps;
    cfg_valid_i  = 1'b1;
    check("cfg_ready_at_offer", cfg_ready_o, 1);
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic consume_result();
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("idle_after_consume", state_o, ST_IDLE);
    check("ready_after_consume", cfg_ready_o, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    step();
    check("rst_state", state_o, ST_IDLE);
    check("rst_cfg_ready", cfg_ready_o, 1);
    check("rst_cnt_reset", cnt_reset_o, 1);
    check("rst_cnt_enable", cnt_enable_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_err", res_err_o, 0);
    check("rst_res_value", res_value_o, 0);
    check("rst_res_runs", res_runs_o, 0);
    check("rst_cnt_target", cnt_target_o, 0);
    reset_i = 1'b0;
    step();

    // basic: init=0 inc=1 target=3 reps=0
    offer_job(4'd0, 4'd1, 4'd3, 4'd0);
    check("basic_c1_load", state_o, ST_LOAD);
    check("basic_c1_cnt_reset", cnt_reset_o, 1);
    check("basic_c1_cnt_enable", cnt_enable_o, 0);
    check("basic_cnt_init", cnt_init_o, 0);
    check("basic_cnt_inc", cnt_inc_o, 1);
    check("basic_cnt_target", cnt_target_o, 3);
    for (int c = 2; c <= 5; c++) begin
      step();
      check("basic_run", state_o, ST_RUN);
      check("basic_run_enable", cnt_enable_o, 1);
      check("basic_run_cnt_reset", cnt_reset_o, 0);
      check("basic_done_timing", cnt_done_i, (c == 5) ? 1 : 0);
    end
    step();
    check("basic_res_valid", res_valid_o, 1);
    check("basic_res_value", res_value_o, 3);
    check("basic_res_runs", res_runs_o, 1);
    check("basic_res_err", res_err_o, 0);
    consume_result();

    // repeat: reps=1
    offer_job(4'd0, 4'd1, 4'd3, 4'd1);
    for (int c = 2; c <= 11; c++) begin
      step();
      if (c == 6)       check("rep_second_load", state_o, ST_LOAD);
      else if (c == 11) check("rep_result", state_o, ST_RESULT);
      else              check("rep_run", state_o, ST_RUN);
    end
    check("rep_res_valid", res_valid_o, 1);
    check("rep_res_runs", res_runs_o, 2);
    check("rep_res_value", res_value_o, 3);

    // backpressure: hold res_ready low 5 cycles while a new job is offered
    cfg_init_i = 4'd7; cfg_inc_i = 4'd2; cfg_target_i = 4'd15; cfg_reps_i = 4'd3;
    cfg_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_res_valid", res_valid_o, 1);
      check("bp_res_value", res_value_o, 3);
      check("bp_res_runs", res_runs_o, 2);
      check("bp_cfg_ready", cfg_ready_o, 0);
      check("bp_cnt_target", cnt_target_o, 3);
    end
    cfg_valid_i = 1'b0;
    consume_result();

    // wide step: init=2 inc=4 target=9 -> 2,6,10 ; done in RUN cycle 3
    offer_job(4'd2, 4'd4, 4'd9, 4'd0);
    step(); check("wide_run1_done", cnt_done_i, 0);
    step(); check("wide_run2_done", cnt_done_i, 0);
    step(); check("wide_run3_done", cnt_done_i, 1);
    check("wide_run3_value", cnt_value_i, 10);
    step();
    check("wide_res_valid", res_valid_o, 1);
    check("wide_res_value", res_value_o, 10);
    check("wide_res_runs", res_runs_o, 1);
    consume_result();

`ifdef COUNTER_CTRL_TIMEOUT_EN
    // timeout: inc=0 never reaches target; 8 RUN cycles (2..9), result at 10
    offer_job(4'd0, 4'd0, 4'd5, 4'd0);
    for (int c = 2; c <= 9; c++) begin
      step();
      check("to_run", state_o, ST_RUN);
    end
    step();
    check("to_res_valid", res_valid_o, 1);
    check("to_res_err", res_err_o, 1);
    check("to_res_value", res_value_o, 0);
    check("to_res_runs", res_runs_o, 0);
    consume_result();
    check("to_err_kept_idle", res_err_o, 1);
`else
    // no watchdog: stuck job stays in RUN with err low
    offer_job(4'd0, 4'd0, 4'd5, 4'd0);
    for (int c = 2; c <= 20; c++) step();
    check("stuck_still_run", state_o, ST_RUN);
    check("stuck_no_valid", res_valid_o, 0);
    check("stuck_no_err", res_err_o, 0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
`endif

    // async reset mid-RUN, between edges
    offer_job(4'd0, 4'd1, 4'd3, 4'd0);
    step();
    check("ar_pre_run", state_o, ST_RUN);
    #2 reset_i = 1'b1;
    #1;
    check("ar_busy", busy_o, 0);
    check("ar_cnt_reset", cnt_reset_o, 1);
    check("ar_cnt_enable", cnt_enable_o, 0);
    check("ar_res_valid", res_valid_o, 0);
    check("ar_cnt_init_cleared", cnt_target_o, 0);
    step();
    reset_i = 1'b0;
    step();

    // new job after reset, with a bounded wait for the result
    offer_job(4'd1, 4'd3, 4'd12, 4'd2);
    begin
      int budget;
      budget = 0;
      while (!res_valid_o && budget < 100) begin
        step();
        budget++;
      end
      // runs: values 1,4,7,10,13 -> done in RUN cycle 5; 3 runs of 6 cycles
      check("post_rst_latency", budget, 18);
    end
    check("post_rst_res_value", res_value_o, 13);
    check("post_rst_res_runs", res_runs_o, 3);
    check("post_rst_res_err", res_err_o, 0);
    consume_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer placed directly upstream of the configurable counter (init/inc/target/enable/done interface). It accepts a counting job over a valid/ready config port, loads the counter through its synchronous reset, enables it until `done` is seen, and repeats for a programmed number of runs. It then returns the last captured count on a valid/ready result port.

## Interface
- `WIDTH`, default 4: counter value width; must match the downstream counter.
- `REP_W`, default 4: width of the repeat field.
- `TIMEOUT`, default 64: maximum RUN cycles per run. Used only with `COUNTER_CTRL_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1: clock.
- `reset_i`  in  1: asynchronous reset, active-high.
- `cfg_valid_i`  in  1: job offered.
- `cfg_ready_o`  out  1: job accepted when high together with `cfg_valid_i`.
- `cfg_init_i`, `cfg_inc_i`, `cfg_target_i`  in  WIDTH each: counter settings for the job.
- `cfg_reps_i`  in  REP_W: extra runs; the job executes `cfg_reps_i+1` runs.
- `cnt_reset_o`  out  1: drives the counter's synchronous reset.
- `cnt_enable_o`  out  1: drives the counter's enable.
- `cnt_init_o`, `cnt_inc_o`, `cnt_target_o`  out  WIDTH each: registered job settings.
- `cnt_value_i`  in  WIDTH: counter value.
- `cnt_done_i`  in  1: counter done; already qualified by enable.
- `res_valid_o`  out  1: result available.
- `res_ready_i`  in  1: result consumed.
- `res_value_o`  out  WIDTH: `cnt_value_i` captured at the last done, or at timeout.
- `res_runs_o`  out  REP_W+1: number of runs completed.
- `res_err_o`  out  1: job aborted by timeout.
- `busy_o`  out  1: high in any state except IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, RESULT.
- IDLE:
  - `cfg_ready_o`=1 and `cnt_reset_o`=1.
  - On handshake: register init/inc/target, set `remaining`=`cfg_reps_i`, clear `res_runs`, `res_err`, `res_value`; go to LOAD.
- LOAD:
  - `cnt_reset_o`=1 and `cnt_enable_o`=0; the counter loads `cnt_init_o` at the end of this cycle.
  - Next state is RUN.
- RUN:
  - `cnt_enable_o`=1 and `cnt_reset_o`=0.
  - On `cnt_done_i`=1: capture `cnt_value_i` into `res_value`; `res_runs` += 1.
  - If `remaining`==0, go to RESULT; otherwise decrement `remaining` and go to LOAD.
- RESULT:
  - `res_valid_o`=1; outputs are held stable until `res_ready_i`=1, then go to IDLE.
- The counter is still enabled in the done cycle, so it increments once more. The captured value is the one sampled in the done cycle.
- `cnt_*` settings come from registers and do not change between handshakes.
- `cfg_valid_i` is ignored outside IDLE. There is no same-cycle bypass from RESULT to IDLE acceptance.
- `res_runs` width REP_W+1 cannot overflow; maximum is 2^REP_W.

## Timing
- Reset (asynchronous, effective immediately):
  - state=IDLE.
  - `cfg_ready_o`=1, `cnt_reset_o`=1, `cnt_enable_o`=0.
  - `busy_o`=0, `res_valid_o`=0, `res_err_o`=0.
  - All config and result registers are 0.
- Reset mid-job abandons the job. `res_valid_o` drops without a handshake.
- Handshake in cycle N gives: LOAD in N+1, first RUN cycle in N+2.
- Each run costs 1 LOAD cycle plus k RUN cycles, where done occurs in RUN cycle k.
- The done cycle of the final run is followed by `res_valid_o`=1 in the next cycle.
- Handshake in RESULT gives IDLE next cycle; `cfg_ready_o`=1 from that cycle.

## Configuration
- `COUNTER_CTRL_TIMEOUT_EN` defined:
  - A watchdog counts RUN cycles and clears in LOAD.
  - When it reaches `TIMEOUT` without done: capture `cnt_value_i`, set `res_err`=1, drop remaining runs, go to RESULT.
  - Done and expiry in the same cycle count as done.
- Undefined:
  - No watchdog; `res_err_o` is tied to 0.
  - RUN waits indefinitely (e.g. `inc`=0 with `target` > `init`).

## Structure
- `counter_ctrl_pkg` holds:
  - the state enum typedef `counter_ctrl_state_t`;
  - default constants `CTRL_WIDTH`=4, `CTRL_REP_W`=4, `CTRL_TIMEOUT`=64.
- Sub-module `counter_ctrl_wdog`:
  - Inputs: `clk_i`, `reset_i`, `clr`, `tick`. Output: `expired`.
  - Instantiated only under `COUNTER_CTRL_TIMEOUT_EN`.

## Test plan
- Basic run: reset, then job init=0 inc=1 target=3 reps=0 accepted at cycle 0. Required: LOAD at 1, RUN 2–5, done at 5, `res_valid_o` at 6 with value=3, runs=1, err=0.
- Repeat: same job with reps=1. Required: second LOAD at 6, RUN 7–10, `res_valid_o` at 11, runs=2.
- Result backpressure: hold `res_ready_i`=0 for 5 cycles. Required: outputs stable and `cfg_ready_o`=0 while `cfg_valid_i`=1; IDLE and ready the cycle after `res_ready_i`.
- Timeout (macro on, TIMEOUT=8): job init=0 inc=0 target=5. Required: after 8 RUN cycles, `res_valid_o`=1, err=1, value=0, runs=0.
- Async reset mid-RUN: assert `reset_i` between edges. Required: `busy_o`=0, `cnt_reset_o`=1, `cnt_enable_o`=0, `res_valid_o`=0 immediately; a new job then runs normally.
- Wide step: init=2 inc=4 target=9. Required: done when the counter is 10; captured value=10; done cycle is RUN cycle 3.
